// File: rtl/seg_adder_mc.sv
// Multi-cycle segmented adder: SEG bits per clock, carry carried between segments in a flop.
// Optional signed-overflow output enabled by defining SEG_ADDER_OVF_EN.
module seg_adder_mc #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SEG_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSEG = WIDTH / SEG;
  localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    logic [NSEG-1:0][SEG-1:0] a;
    logic [NSEG-1:0][SEG-1:0] b;
  } opnd_t;

  state_e                   state_q, state_d;
  opnd_t                    opnd_q, opnd_d;
  logic                     carry_q, carry_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NSEG-1:0][SEG-1:0] sum_q, sum_d;
  logic                     cout_q, cout_d;
  logic                     ovf_q, ovf_d;

  logic [SEG-1:0] seg_a, seg_b;
  logic [SEG:0]   seg_sum;
  logic           last_seg;

  // Segment currently being added, selected by the count.
  always_comb begin
    seg_a = '0;
    seg_b = '0;
    for (int i = 0; i < NSEG; i++) begin
      if (cnt_q == CW'(i)) begin
        seg_a = opnd_q.a[i];
        seg_b = opnd_q.b[i];
      end
    end
    seg_sum  = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, carry_q};
    last_seg = (cnt_q == CW'(NSEG - 1));
  end

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opnd_d  = '{a: a, b: b};
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NSEG; i++) begin
          if (cnt_q == CW'(i)) sum_d[i] = seg_sum[SEG-1:0];
        end
        carry_d = seg_sum[SEG];
        if (last_seg) begin
          // Last segment holds the sign bits, so overflow is judged here.
          cout_d  = seg_sum[SEG];
          ovf_d   = (opnd_q.a[NSEG-1][SEG-1] == opnd_q.b[NSEG-1][SEG-1]) &&
                    (seg_sum[SEG-1] != opnd_q.a[NSEG-1][SEG-1]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef SEG_ADDER_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_seg_adder_mc.sv
// Bench for seg_adder_mc: three instances (SEG=8/32/4) share stimulus and are
// compared against plain 33-bit arithmetic.
module tb_seg_adder_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic [2:0]  ir, ov, bs, co, of;
  logic [31:0] sm [3];

  int n_chk = 0;
  int n_pass = 0;

  function automatic int seg_of(int k);
    return (k == 0) ? 8 : ((k == 1) ? 32 : 4);
  endfunction

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    seg_adder_mc #(.WIDTH(32), .SEG(seg_of(k))) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (ir[k]),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .out_valid(ov[k]),
      .out_ready(out_ready),
      .sum      (sm[k]),
      .cout     (co[k]),
      .busy     (bs[k])
`ifdef SEG_ADDER_OVF_EN
      ,
      .ovf      (of[k])
`endif
    );
  end

`ifndef SEG_ADDER_OVF_EN
  assign of = '0;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction through all three instances; optionally hold DONE for
  // 'hold' cycles while offering new operands that must be ignored.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_,
                       input logic tc, input int hold);
    logic [32:0] full;
    logic        eovf;
    int          lat [3];
    int          n;
    full = {1'b0, ta} + {1'b0, tb_} + 33'(tc);
    eovf = (ta[31] == tb_[31]) && (full[31] != ta[31]);
    chk("idle_ready", ir, 3'b111);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom);
    chk("run_busy", bs, 3'b111);
    chk("run_ready", ir, 3'b000);
    for (int k = 0; k < 3; k++) lat[k] = -1;
    n = 0;
    while (ov !== 3'b111 && n < 20) begin
      tick();
      n++;
      for (int k = 0; k < 3; k++) if (ov[k] && lat[k] < 0) lat[k] = n;
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lat_seg%0d", seg_of(k)), 64'(lat[k]), 64'(32 / seg_of(k)));
      chk($sformatf("sum_seg%0d %h+%h+%0d", seg_of(k), ta, tb_, tc), sm[k], full[31:0]);
      chk($sformatf("cout_seg%0d %h+%h+%0d", seg_of(k), ta, tb_, tc), co[k], full[32]);
`ifdef SEG_ADDER_OVF_EN
      chk($sformatf("ovf_seg%0d %h+%h+%0d", seg_of(k), ta, tb_, tc), of[k], eovf);
`endif
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom);
      tick();
      chk("hold_valid", ov, 3'b111);
      chk("hold_sum", sm[0], full[31:0]);
      chk("hold_cout", co[0], full[32]);
      chk("hold_ready", ir, 3'b000);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_ready", ir, 3'b111);
    chk("release_valid", ov, 3'b000);
  endtask

  function automatic logic [31:0] sweep_val(int i);
    return (i < 15) ? 32'(i) : 32'hFFFF_FFF0 + 32'(i - 15);
  endfunction

  initial begin
    #1;
    chk("rst_sum", sm[0], 32'h0);
    chk("rst_cout", co, 3'b000);
    chk("rst_valid", ov, 3'b000);
    chk("rst_ready", ir, 3'b111);
    chk("rst_busy", bs, 3'b000);
    #12 rst_n = 1'b1;
    tick();

    do_op(32'h0000_000F, 32'h0000_0001, 1'b0, 0);
    do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
    do_op($urandom, $urandom, 1'b1, 6);
    tick();
    chk("ignored_valid", ov, 3'b000);
    chk("ignored_busy", bs, 3'b000);

    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);

    // Abort mid-operation with the asynchronous reset.
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0);
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_valid", ov, 3'b000);
    chk("abort_sum", sm[0], 32'h0);
    chk("abort_cout", co, 3'b000);
    chk("abort_ready", ir, 3'b111);
    chk("abort_busy", bs, 3'b000);
    #2 rst_n = 1'b1;
    tick();
    do_op(32'h3, 32'h4, 1'b0, 0);

    for (int i = 0; i < 30; i++)
      for (int j = 0; j < 30; j++)
        for (int c = 0; c < 2; c++)
          do_op(sweep_val(i), sweep_val(j), 1'(c), 0);

    for (int r = 0; r < 40; r++)
      do_op($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 2)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

endmodule
